// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift, ACK.
// Build option: define PS2_TX_RETRY_EN to retry NACK/timeout up to 2 times.
//
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   kb_clk_in, kb_data_in   PS/2 pad inputs (asynchronous)
//   kb_clk_oe, kb_data_oe   open-drain pull-low enables (1 = drive low)
//   tx_data, tx_valid       command byte and request, taken when tx_ready
//   tx_ready                high only while idle
//   busy                    high in every non-idle state
//   tx_done, tx_err         one-cycle completion pulses (ACK / failure)

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kb_clk_in,
    input  logic       kb_data_in,
    output logic       kb_clk_oe,
    output logic       kb_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT
    } state_t;

    state_t state_q, state_n;

    logic clk_s1, clk_s2, clk_d;
    logic dat_s1, dat_s2;
    logic fall;

    logic [7:0]    byte_q, byte_n;
    logic          par_q, par_n;
    logic [3:0]    bit_q, bit_n;
    logic [IW-1:0] inh_q, inh_n;
    logic [TW-1:0] to_q, to_n;
    logic          ok_q, ok_n;
    logic          doe_q, doe_n;

    logic to_hit;
    logic can_retry;
    logic retry_go;

    // Idle PS/2 lines are high, so the synchronizers reset to 1 to
    // avoid a phantom falling edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= kb_clk_in;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= kb_data_in;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = clk_d & ~clk_s2;

    // to_q holds the number of cycles elapsed since the REQ cycle.
    assign to_hit = ((state_q == S_SHIFT) || (state_q == S_ACK))
                  && (to_q == TW'(TIMEOUT_CYCLES));

`ifdef PS2_TX_RETRY_EN
    logic [1:0] att_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            att_q <= 2'd0;
        end else if (state_q == S_IDLE && tx_valid) begin
            att_q <= 2'd0;
        end else if (retry_go) begin
            att_q <= att_q + 2'd1;
        end
    end

    assign can_retry = (att_q != 2'd2);
`else
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            byte_q  <= 8'd0;
            par_q   <= 1'b0;
            bit_q   <= 4'd0;
            inh_q   <= '0;
            to_q    <= '0;
            ok_q    <= 1'b0;
            doe_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            byte_q  <= byte_n;
            par_q   <= par_n;
            bit_q   <= bit_n;
            inh_q   <= inh_n;
            to_q    <= to_n;
            ok_q    <= ok_n;
            doe_q   <= doe_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        byte_n   = byte_q;
        par_n    = par_q;
        bit_n    = bit_q;
        inh_n    = inh_q;
        to_n     = to_q;
        ok_n     = ok_q;
        doe_n    = doe_q;
        tx_done  = 1'b0;
        tx_err   = 1'b0;
        retry_go = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                doe_n = 1'b0;
                if (tx_valid) begin
                    byte_n  = tx_data;
                    par_n   = ~^tx_data;
                    inh_n   = IW'(INHIBIT_CYCLES - 1);
                    ok_n    = 1'b0;
                    state_n = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                doe_n = 1'b0;
                if (inh_q == '0) begin
                    doe_n   = 1'b1;
                    state_n = S_REQ;
                end else begin
                    inh_n = inh_q - 1'b1;
                end
            end

            S_REQ: begin
                bit_n   = 4'd0;
                to_n    = TW'(1);
                state_n = S_SHIFT;
            end

            S_SHIFT, S_ACK: begin
                to_n = to_q + 1'b1;
                if (to_hit) begin
                    doe_n = 1'b0;
                    if (can_retry) begin
                        retry_go = 1'b1;
                    end else begin
                        tx_err  = 1'b1;
                        state_n = S_IDLE;
                    end
                end else if (fall && state_q == S_SHIFT) begin
                    bit_n = bit_q + 4'd1;
                    unique case (1'b1)
                        (bit_q < 4'd8): doe_n = ~byte_q[bit_q[2:0]];
                        (bit_q == 4'd8): doe_n = ~par_q;
                        default: begin
                            doe_n   = 1'b0;
                            state_n = S_ACK;
                        end
                    endcase
                end else if (fall) begin
                    ok_n    = ~dat_s2;
                    state_n = S_WAIT;
                end
            end

            S_WAIT: begin
                doe_n = 1'b0;
                if (clk_s2 && dat_s2) begin
                    if (ok_q) begin
                        tx_done = 1'b1;
                        state_n = S_IDLE;
                    end else if (can_retry) begin
                        retry_go = 1'b1;
                    end else begin
                        tx_err  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end

            default: begin
                doe_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        if (retry_go) begin
            inh_n   = IW'(INHIBIT_CYCLES - 1);
            ok_n    = 1'b0;
            doe_n   = 1'b0;
            state_n = S_INHIBIT;
        end
    end

    // The timeout term releases data in the very cycle the limit is hit.
    assign kb_clk_oe  = (state_q == S_INHIBIT);
    assign kb_data_oe = doe_q & ~to_hit;
    assign tx_ready   = (state_q == S_IDLE);
    assign busy       = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table vectors, random bytes, corner sequences.
// A simple PS/2 device model clocks frames and answers ACK/NACK.

module tb_ps2_host_tx;

    localparam int INH = 60;
    localparam int TO  = 1500;
    localparam int H   = 20;

`ifdef PS2_TX_RETRY_EN
    localparam int ATT = 3;
`else
    localparam int ATT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       kb_clk_in, kb_data_in;
    logic       kb_clk_oe, kb_data_oe;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device.
    assign kb_clk_in  = ~kb_clk_oe & dev_clk;
    assign kb_data_in = ~kb_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kb_clk_in(kb_clk_in),
        .kb_data_in(kb_data_in),
        .kb_clk_oe(kb_clk_oe),
        .kb_data_oe(kb_data_oe),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .tx_done(tx_done),
        .tx_err(tx_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int n_inh = 0;
    int inh_run = 0;
    int inh_len = 0;
    int req_cyc = 0;
    int err_cyc = 0;
    int viol = 0;
    logic prev_oe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if (kb_clk_oe) inh_run <= prev_oe ? inh_run + 1 : 1;
        if (kb_clk_oe && !prev_oe) n_inh <= n_inh + 1;
        if (!kb_clk_oe && prev_oe) begin
            inh_len <= inh_run;
            req_cyc <= cyc;
        end
        viol <= viol + int'(busy === tx_ready)
                     + int'(kb_data_oe && tx_ready)
                     + int'(kb_clk_oe && kb_data_oe)
                     + int'(tx_done && tx_err);
        prev_oe <= kb_clk_oe;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    // Reference frame: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = ((b >> i) & 1) != 0;
            ones += (b >> i) & 1;
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    // Device: nfall falling edges; the line is read late in each low
    // phase. With nfall < 11 the clock is left low at the end.
    task automatic dev_frame(input bit ack, input int nfall,
                             output logic [9:0] got);
        got = '0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nfall; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (i < 10) got[i] = kb_data_in;
            if (i == nfall - 1 && nfall < 11) return;
            if (i == 9) dev_data = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack,
                             input bit clocks, input bit poke,
                             output logic [9:0] got, output int nd,
                             output int ne, output int ni);
        int d0, e0, i0, lim;
        logic pv;
        got = '0;
        lim = 0;
        while (!tx_ready && lim < 1000) begin
            @(negedge clk);
            lim++;
        end
        d0 = n_done;
        e0 = n_err;
        i0 = n_inh;
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk("ready_drop", int'(tx_ready), 0);
        lim = 0;
        pv  = 1'b0;
        while (n_done == d0 && n_err == e0
               && lim < ATT * (INH + TO + 200)) begin
            if (poke && lim == 5) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            if (pv && !kb_clk_oe && clocks) begin
                if (poke) begin
                    tx_data  = 8'hAA;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
                dev_frame(ack, 11, got);
            end
            pv = kb_clk_oe;
            @(negedge clk);
            lim++;
        end
        tx_valid = 1'b0;
        chk("frame_end_seen", int'(n_done != d0 || n_err != e0), 1);
        lim = 0;
        while (!tx_ready && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        @(negedge clk);
        nd = n_done - d0;
        ne = n_err - e0;
        ni = n_inh - i0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         par;
        int         done;
        int         err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] got, ef;
        int nd, ne, ni, d0, e0, lim;
        bit ack;
        logic [7:0] b;

        tbl[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
        tbl[3] = '{8'h01, 1'b1, 1'b0, 1, 0};
        tbl[4] = '{8'h80, 1'b1, 1'b0, 1, 0};
        tbl[5] = '{8'hF4, 1'b0, 1'b0, 0, 1};

        #1 rst_n = 1'b0;
        #2;
        chk("rst_clk_oe", int'(kb_clk_oe), 0);
        chk("rst_data_oe", int'(kb_data_oe), 0);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(tx_done), 0);
        chk("rst_err", int'(tx_err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_frame(tbl[v].data, tbl[v].ack, 1'b1, 1'b0,
                      got, nd, ne, ni);
            chk("tbl_byte", int'(got[7:0]), int'(tbl[v].data));
            chk("tbl_parity", int'(got[8]), int'(tbl[v].par));
            chk("tbl_stop", int'(got[9]), 1);
            chk("tbl_done", nd, tbl[v].done);
            chk("tbl_err", ne, tbl[v].err);
            chk("tbl_inhibits", ni, tbl[v].ack ? 1 : ATT);
            chk("tbl_inh_len", inh_len, INH);
            chk("tbl_oe_end", int'({kb_clk_oe, kb_data_oe}), 0);
        end

        for (int r = 0; r < 8; r++) begin
            b   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            ef  = frame_bits(b);
            run_frame(b, ack, 1'b1, 1'b0, got, nd, ne, ni);
            chk("rnd_bits", int'(got), int'(ef));
            chk("rnd_done", nd, ack ? 1 : 0);
            chk("rnd_err", ne, ack ? 0 : 1);
            chk("rnd_inhibits", ni, ack ? 1 : ATT);
        end

        // Device never clocks: timeout after the last REQ.
        run_frame(8'h5A, 1'b1, 1'b0, 1'b0, got, nd, ne, ni);
        chk("to_done", nd, 0);
        chk("to_err", ne, 1);
        chk("to_inhibits", ni, ATT);
        chk("to_latency", err_cyc - req_cyc, TO);
        chk("to_oe_end", int'({kb_clk_oe, kb_data_oe}), 0);

        // New request while busy must not replace the latched byte.
        run_frame(8'hFF, 1'b1, 1'b1, 1'b1, got, nd, ne, ni);
        chk("poke_byte", int'(got[7:0]), 8'hFF);
        chk("poke_done", nd, 1);

        // Reset after the 5th falling edge of a frame.
        d0 = n_done;
        e0 = n_err;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        lim = 0;
        while (!(prev_oe && !kb_clk_oe) && lim < INH + 50) begin
            @(negedge clk);
            lim++;
        end
        chk("rst_req_seen", int'(lim < INH + 50), 1);
        dev_frame(1'b1, 5, got);
        chk("mid_data_oe", int'(kb_data_oe), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_clk_oe", int'(kb_clk_oe), 0);
        chk("mid_rst_data_oe", int'(kb_data_oe), 0);
        chk("mid_rst_ready", int'(tx_ready), 1);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_pulses", (n_done - d0) + (n_err - e0), 0);
        run_frame(8'hF4, 1'b1, 1'b1, 1'b0, got, nd, ne, ni);
        chk("post_rst_byte", int'(got[7:0]), 8'hF4);
        chk("post_rst_done", nd, 1);
        chk("post_rst_err", ne, 0);

        chk("invariants", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
